// File: rtl/traceback_controller_pkg.sv
// Shared encodings for the Needleman-Wunsch traceback controller:
// direction symbols, alignment op codes and controller FSM states.
package traceback_controller_pkg;

  localparam logic [2:0] DIR_DIAG = 3'b001;
  localparam logic [2:0] DIR_UP   = 3'b010;
  localparam logic [2:0] DIR_LEFT = 3'b100;

  localparam logic [1:0] OP_DIAG = 2'b00;
  localparam logic [1:0] OP_GAPB = 2'b01;
  localparam logic [1:0] OP_GAPA = 2'b10;

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, EMIT, DONE, ERR} state_t;

endpackage

// File: rtl/traceback_controller_dir_decode.sv
// Priority decode of a direction symbol into an alignment op.
// Ties resolve DIAG > UP > LEFT; an all-zero symbol is flagged invalid.
module traceback_controller_dir_decode
  import traceback_controller_pkg::*;
(
  input  logic [2:0] symbol,
  output logic [1:0] op,
  output logic       invalid
);

  always_comb begin
    op      = OP_DIAG;
    invalid = 1'b0;
    if (|(symbol & DIR_DIAG))      op = OP_DIAG;
    else if (|(symbol & DIR_UP))   op = OP_GAPB;
    else if (|(symbol & DIR_LEFT)) op = OP_GAPA;
    else                           invalid = 1'b1;
  end

endmodule

// File: rtl/traceback_controller.sv
// Traceback walker: reads direction symbols from (N,N) back to (0,0) and
// streams one alignment op per step on a valid/ready interface.
module traceback_controller
  import traceback_controller_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int RD_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       symbol_in,
  output logic [BitAddr:0] i_t,
  output logic [BitAddr:0] j_t,
  output logic             en_traceB,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op,
  output logic [BitAddr:0] op_i,
  output logic [BitAddr:0] op_j,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BitAddr+1:0] op_count
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0]      LAT     = CW'(RD_LAT);
  localparam logic [BitAddr:0]   IDX_N   = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0]   IDX_ONE = (BitAddr + 1)'(1);
  localparam logic [BitAddr+1:0] CNT_ONE = (BitAddr + 2)'(1);

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    dec_op;
  logic          dec_invalid;
  logic          start_ok, fire, load_op, at_origin, on_edge, sample;

  traceback_controller_dir_decode u_dec (
    .symbol  (symbol_in),
    .op      (dec_op),
    .invalid (dec_invalid)
  );

  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign at_origin = (i_t == '0) && (j_t == '0);
  assign on_edge   = (i_t == '0) || (j_t == '0);
  assign sample    = (state == WAIT) && (wait_cnt == LAT);
  assign op_valid  = (state == EMIT);
  assign fire      = op_valid && op_ready;
  assign busy      = (state == CHECK) || (state == WAIT) || (state == EMIT);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign load_op   = (state != EMIT) && (state_n == EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    en_traceB = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start_ok) state_n = CHECK;
      CHECK: begin
        if (at_origin)    state_n = DONE;
        else if (on_edge) state_n = EMIT;
        else begin
          en_traceB = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT:    if (sample) state_n = dec_invalid ? ERR : EMIT;
      EMIT:    if (op_ready) state_n = CHECK;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_t      <= '0;
      j_t      <= '0;
      op_i     <= '0;
      op_j     <= '0;
      op       <= OP_DIAG;
      op_count <= '0;
      wait_cnt <= '0;
    end else begin
      if (start_ok) begin
        i_t      <= IDX_N;
        j_t      <= IDX_N;
        op_count <= '0;
      end
      // WAIT is entered with the count at 1 so the symbol is taken RD_LAT
      // cycles after the read enable.
      if (state == CHECK)     wait_cnt <= CW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (load_op) begin
        op   <= (state == CHECK) ? ((i_t == '0) ? OP_GAPA : OP_GAPB) : dec_op;
        op_i <= i_t;
        op_j <= j_t;
      end
      if (fire) begin
        op_count <= op_count + CNT_ONE;
        case (op)
          OP_DIAG: begin
            i_t <= i_t - IDX_ONE;
            j_t <= j_t - IDX_ONE;
          end
          OP_GAPB: i_t <= i_t - IDX_ONE;
          default: j_t <= j_t - IDX_ONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traceback_controller.sv
// Scoreboard bench: a behavioural direction RAM with two-cycle read latency,
// an independent path model pushing expected ops, and a handshake monitor.
module tb_traceback_controller;

  localparam int N  = 4;
  localparam int BA = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    symbol_in;
  logic [BA:0]   i_t, j_t, op_i, op_j;
  logic          en_traceB, op_valid, busy, done, err;
  logic          op_ready = 1'b1;
  logic [1:0]    op;
  logic [BA+1:0] op_count;

  traceback_controller #(.N(N), .RD_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .symbol_in (symbol_in),
    .i_t       (i_t),
    .j_t       (j_t),
    .en_traceB (en_traceB),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .op_i      (op_i),
    .op_j      (op_j),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Direction RAM: address registered on en_traceB, data registered next
  // cycle; symbol is 0 whenever no read is landing so a mistimed sample errors.
  logic [2:0]  ram [0:N][0:N];
  logic [BA:0] ra_i, ra_j;
  logic        rd_pend;
  always @(posedge clk) begin
    rd_pend   <= en_traceB;
    if (en_traceB) begin
      ra_i <= i_t;
      ra_j <= j_t;
    end
    symbol_in <= rd_pend ? ram[ra_i][ra_j] : 3'b000;
  end

  typedef struct {
    logic [1:0] op;
    int         i;
    int         j;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0, reads = 0, reads_base = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (en_traceB) reads++;
      if (op_valid && op_ready) begin
        if (q.size() == 0) chk("extra_op", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("op", op, e.op);
          chk("op_i", op_i, e.i);
          chk("op_j", op_j, e.j);
        end
      end
    end
  end

  function automatic void fill(input logic [2:0] s);
    for (int a = 0; a <= N; a++)
      for (int b = 0; b <= N; b++) ram[a][b] = s;
  endfunction

  function automatic void push(input logic [1:0] o, input int i, input int j);
    exp_t e;
    e.op = o; e.i = i; e.j = j;
    q.push_back(e);
  endfunction

  // Walk the RAM contents the way the aligner should, queueing each op.
  task automatic model(output bit x_err, output int cnt, output int rd,
                       output int fi, output int fj);
    int i = N, j = N;
    logic [2:0] s;
    x_err = 0; cnt = 0; rd = 0;
    while (i != 0 || j != 0) begin
      if (i == 0) begin push(2'b10, i, j); j--; end
      else if (j == 0) begin push(2'b01, i, j); i--; end
      else begin
        rd++;
        s = ram[i][j];
        if (s[0])      begin push(2'b00, i, j); i--; j--; end
        else if (s[1]) begin push(2'b01, i, j); i--; end
        else if (s[2]) begin push(2'b10, i, j); j--; end
        else begin x_err = 1; break; end
      end
      cnt++;
    end
    fi = i; fj = j;
  endtask

  task automatic go();
    reads_base = reads;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!op_valid && k < 100) begin @(negedge clk); k++; end
    if (!op_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic finish_run(input string tag);
    bit x_err; int cnt, rd, fi, fj, k;
    model(x_err, cnt, rd, fi, fj);
    go();
    k = 0;
    while (!(done || err) && k < 400) begin @(negedge clk); k++; end
    chk({tag, "_done"}, done, !x_err);
    chk({tag, "_err"}, err, x_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, op_count, cnt);
    chk({tag, "_reads"}, reads - reads_base, rd);
    chk({tag, "_i_t"}, i_t, fi);
    chk({tag, "_j_t"}, j_t, fj);
    chk({tag, "_q_left"}, q.size(), 0);
  endtask

  initial begin
    exp_t d;
    logic [1:0] h_op;
    logic [BA:0] h_i, h_j;
    bit x_err; int cnt, rd, fi, fj;

    #12;
    chk("rst_outputs", {i_t, j_t, op_i, op_j, op_count, op, en_traceB,
                        op_valid, busy, done, err}, 0);
    #10 rst = 1'b1;

    fill(3'b001);
    finish_run("diag");

    fill(3'b001);
    for (int a = 1; a <= N; a++) ram[a][N] = 3'b010;
    finish_run("col_up");

    fill(3'b001); ram[N][N] = 3'b111;
    finish_run("tie111");
    fill(3'b001); ram[N][N] = 3'b110;
    finish_run("tie110");

    fill(3'b001); ram[3][3] = 3'b000;
    finish_run("zero_sym");

    // Backpressure: first op passes, second op stalls with an ignored start.
    fill(3'b001);
    op_ready = 1'b0;
    model(x_err, cnt, rd, fi, fj);
    go();
    wait_valid("bp1");
    @(posedge clk); #1 op_ready = 1'b1;
    @(posedge clk); #1 op_ready = 1'b0;
    wait_valid("bp2");
    h_op = op; h_i = op_i; h_j = op_j;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("bp_valid", op_valid, 1);
      chk("bp_op", op, h_op);
      chk("bp_op_i", op_i, h_i);
      chk("bp_op_j", op_j, h_j);
      chk("bp_i_t", i_t, 3);
      chk("bp_count", op_count, 1);
    end
    @(posedge clk); #1 op_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_final_count", op_count, cnt);
    chk("bp_q_left", q.size(), 0);

    // Asynchronous reset in the middle of a RAM wait.
    fill(3'b001);
    model(x_err, cnt, rd, fi, fj);
    go();
    for (int k = 0; k < 50 && !en_traceB; k++) @(negedge clk);
    chk("mid_en_seen", en_traceB, 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mid_rst_outputs", {i_t, j_t, op_i, op_j, op_count, op, en_traceB,
                            op_valid, busy, done, err}, 0);
    while (q.size() != 0) d = q.pop_front();
    @(posedge clk); #1 rst = 1'b1;
    model(x_err, cnt, rd, fi, fj);
    go();
    chk("restart_i_t", i_t, N);
    chk("restart_j_t", j_t, N);
    chk("restart_count", op_count, 0);
    chk("restart_busy", busy, 1);
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("restart_done", done, 1);
    chk("restart_final_count", op_count, cnt);
    chk("restart_q_left", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
